// File: rtl/tile_buffer_reader.sv
// Raster-order reader for the maze frame buffer: issues read coordinates, aligns the
// returned tile colour with the pixel stream and overlays the tile grid and robot outline.
module tile_buffer_reader #(
   parameter int unsigned SCREEN_WIDTH  = 330,
   parameter int unsigned SCREEN_HEIGHT = 330,
   parameter int unsigned BLOCK_SIZE    = 30,
   parameter int unsigned RD_LATENCY    = 2,
   parameter logic [7:0]  GRID_COLOR    = 8'h92
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        grid_en,
   input  logic [3:0]  robot_x,
   input  logic [3:0]  robot_y,
   input  logic [1:0]  rd_data,
   output logic [14:0] rd_x,
   output logic [14:0] rd_y,
   output logic        rd_en,
   output logic [7:0]  pixel_color,
   output logic        frame_start
);

   localparam int unsigned PIX_W   = 10;
   localparam int unsigned COORD_W = 15;
   localparam int unsigned OFF_W   = $clog2(BLOCK_SIZE);
   localparam int unsigned TILE_W  = 4;
   localparam int unsigned TILES_X = SCREEN_WIDTH / BLOCK_SIZE;
   localparam int unsigned TILES_Y = SCREEN_HEIGHT / BLOCK_SIZE;
   localparam int unsigned DLY_W   = RD_LATENCY + 1;

   logic [PIX_W-1:0]   prev_x_q, prev_x_d, prev_y_q, prev_y_d;
   logic [OFF_W-1:0]   x_off_q, x_off_d, y_off_q, y_off_d;
   logic [TILE_W-1:0]  x_tile_q, x_tile_d, y_tile_q, y_tile_d;
   logic               prev_origin_q, prev_origin_d;
   logic               lat_grid_q, lat_grid_d, lat_hl_q, lat_hl_d;
   logic [TILE_W-1:0]  lat_rx_q, lat_rx_d, lat_ry_q, lat_ry_d;
   logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
   logic               rd_en_q, rd_en_d;
   logic               frame_start_q, frame_start_d;
   logic [DLY_W-1:0]   dly_in_q, dly_in_d, dly_grid_q, dly_grid_d, dly_outl_q, dly_outl_d;
   logic [7:0]         pixel_color_q, pixel_color_d;

   logic origin_c, in_area_c, is_grid_c, near_edge_c, is_outline_c;

   // Offset/tile counters; the _d values are the offsets of the pixel presented this cycle
   always_comb begin
      x_off_d  = x_off_q;
      x_tile_d = x_tile_q;
      y_off_d  = y_off_q;
      y_tile_d = y_tile_q;
      prev_x_d = pixel_x;
      prev_y_d = pixel_y;
      if (pixel_x == '0) begin
         x_off_d  = '0;
         x_tile_d = '0;
      end else if (pixel_x != prev_x_q && x_tile_q < TILE_W'(TILES_X)) begin
         if (x_off_q == OFF_W'(BLOCK_SIZE - 1)) begin
            x_off_d  = '0;
            x_tile_d = x_tile_q + TILE_W'(1);
         end else begin
            x_off_d = x_off_q + OFF_W'(1);
         end
      end
      if (pixel_y == '0) begin
         y_off_d  = '0;
         y_tile_d = '0;
      end else if (pixel_y != prev_y_q && y_tile_q < TILE_W'(TILES_Y)) begin
         if (y_off_q == OFF_W'(BLOCK_SIZE - 1)) begin
            y_off_d  = '0;
            y_tile_d = y_tile_q + TILE_W'(1);
         end else begin
            y_off_d = y_off_q + OFF_W'(1);
         end
      end
   end

   // Frame start detection, overlay control latch and issue stage
   always_comb begin
      origin_c      = (pixel_x == '0) && (pixel_y == '0);
      frame_start_d = origin_c && !prev_origin_q;
      prev_origin_d = origin_c;
      lat_grid_d    = lat_grid_q;
      lat_hl_d      = lat_hl_q;
      lat_rx_d      = lat_rx_q;
      lat_ry_d      = lat_ry_q;
      if (frame_start_d) begin
         lat_grid_d = grid_en;
         lat_hl_d   = (robot_x < TILE_W'(TILES_X)) && (robot_y < TILE_W'(TILES_Y));
         lat_rx_d   = robot_x;
         lat_ry_d   = robot_y;
      end

      in_area_c    = (pixel_x < PIX_W'(SCREEN_WIDTH)) && (pixel_y < PIX_W'(SCREEN_HEIGHT));
      is_grid_c    = lat_grid_d && (x_off_d == '0 || y_off_d == '0);
      near_edge_c  = (x_off_d < OFF_W'(2)) || (x_off_d > OFF_W'(BLOCK_SIZE - 3)) ||
                     (y_off_d < OFF_W'(2)) || (y_off_d > OFF_W'(BLOCK_SIZE - 3));
      is_outline_c = lat_hl_d && (x_tile_d == lat_rx_d) && (y_tile_d == lat_ry_d) && near_edge_c;

      rd_x_d  = in_area_c ? COORD_W'(pixel_x) : rd_x_q;
      rd_y_d  = in_area_c ? COORD_W'(pixel_y) : rd_y_q;
      rd_en_d = in_area_c;

      // Bit 0 is issue-aligned; the top bit meets rd_data
      dly_in_d   = {dly_in_q[DLY_W-2:0], in_area_c};
      dly_grid_d = {dly_grid_q[DLY_W-2:0], is_grid_c};
      dly_outl_d = {dly_outl_q[DLY_W-2:0], is_outline_c};
   end

   // Output colour selection
   always_comb begin
      pixel_color_d = 8'h00;
      if (!dly_in_q[DLY_W-1]) begin
         pixel_color_d = 8'h00;
      end else if (dly_outl_q[DLY_W-1]) begin
         pixel_color_d = 8'hFF;
      end else if (dly_grid_q[DLY_W-1]) begin
         pixel_color_d = GRID_COLOR;
      end else begin
         case (rd_data)
            2'b00:   pixel_color_d = 8'h00;
            2'b01:   pixel_color_d = 8'h03;
            2'b10:   pixel_color_d = 8'hE0;
            default: pixel_color_d = 8'hF0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_x_q      <= '0;
         prev_y_q      <= '0;
         x_off_q       <= '0;
         x_tile_q      <= '0;
         y_off_q       <= '0;
         y_tile_q      <= '0;
         prev_origin_q <= 1'b0;
         lat_grid_q    <= 1'b0;
         lat_hl_q      <= 1'b0;
         lat_rx_q      <= '0;
         lat_ry_q      <= '0;
         rd_x_q        <= '0;
         rd_y_q        <= '0;
         rd_en_q       <= 1'b0;
         frame_start_q <= 1'b0;
         dly_in_q      <= '0;
         dly_grid_q    <= '0;
         dly_outl_q    <= '0;
         pixel_color_q <= 8'h00;
      end else begin
         prev_x_q      <= prev_x_d;
         prev_y_q      <= prev_y_d;
         x_off_q       <= x_off_d;
         x_tile_q      <= x_tile_d;
         y_off_q       <= y_off_d;
         y_tile_q      <= y_tile_d;
         prev_origin_q <= prev_origin_d;
         lat_grid_q    <= lat_grid_d;
         lat_hl_q      <= lat_hl_d;
         lat_rx_q      <= lat_rx_d;
         lat_ry_q      <= lat_ry_d;
         rd_x_q        <= rd_x_d;
         rd_y_q        <= rd_y_d;
         rd_en_q       <= rd_en_d;
         frame_start_q <= frame_start_d;
         dly_in_q      <= dly_in_d;
         dly_grid_q    <= dly_grid_d;
         dly_outl_q    <= dly_outl_d;
         pixel_color_q <= pixel_color_d;
      end
   end

   assign rd_x        = rd_x_q;
   assign rd_y        = rd_y_q;
   assign rd_en       = rd_en_q;
   assign pixel_color = pixel_color_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tile_buffer_reader.sv
// Bench for tile_buffer_reader: four instances (read latency 2,1,3,4) share one pixel
// stream; each has its own latency-matched memory model; a reference model plus hand vectors.
module tb_tile_buffer_reader;

   localparam int NI    = 4;
   localparam int NSPOT = 15;
   localparam int NVEC  = 13;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] pixel_x = 10'd700;
   logic [9:0] pixel_y = 10'd700;
   logic       grid_en = 1'b0;
   logic [3:0] robot_x = 4'd15;
   logic [3:0] robot_y = 4'd0;

   logic [1:0]  rdd_w [NI];
   logic [14:0] rdx_w [NI];
   logic [14:0] rdy_w [NI];
   logic        ren_w [NI];
   logic [7:0]  col_w [NI];
   logic        fs_w  [NI];

   always #5 clk = ~clk;

   function automatic logic [1:0] memf(input int x, input int y);
      if (y == 5 && x == 10) return 2'd3;
      if (y == 5 && x == 11) return 2'd1;
      if (y == 7) return 2'(x % 4);
      return 2'((x + y) % 3 + 1);
   endfunction

   function automatic logic [7:0] cmap(input logic [1:0] c);
      case (c)
         2'b00:   return 8'h00;
         2'b01:   return 8'h03;
         2'b10:   return 8'hE0;
         default: return 8'hF0;
      endcase
   endfunction

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
      logic [14:0] ax [4];
      logic [14:0] ay [4];
      always @(posedge clk) begin
         ax[0] <= rdx_w[g];
         ay[0] <= rdy_w[g];
         for (int i = 1; i < 4; i++) begin
            ax[i] <= ax[i-1];
            ay[i] <= ay[i-1];
         end
      end
      assign rdd_w[g] = memf(int'(ax[L-1]), int'(ay[L-1]));

      tile_buffer_reader #(.RD_LATENCY(L)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .pixel_x     (pixel_x),
         .pixel_y     (pixel_y),
         .grid_en     (grid_en),
         .robot_x     (robot_x),
         .robot_y     (robot_y),
         .rd_data     (rdd_w[g]),
         .rd_x        (rdx_w[g]),
         .rd_y        (rdy_w[g]),
         .rd_en       (ren_w[g]),
         .pixel_color (col_w[g]),
         .frame_start (fs_w[g])
      );
   end

   typedef struct {
      logic [7:0]  col;
      logic        fs;
      logic        ren;
      logic [14:0] rx;
      logic [14:0] ry;
      logic        rst;
      logic        hv;
      logic [7:0]  hcol;
      logic        hren;
      logic [14:0] hrdx;
   } hist_t;

   typedef struct {
      int         x;
      int         y;
      logic       ren;
      int         rdx;
      logic [7:0] col;
   } vec_t;

   typedef struct {
      int         fr;
      int         x;
      int         y;
      logic [7:0] col;
   } spot_t;

   hist_t hist [8];
   vec_t  tbl [NVEC];
   spot_t spots [NSPOT];

   int errs = 0;
   int checks = 0;
   int fs_seen = 0;
   logic [7:0] last_col = 8'h00;

   logic       c_grid = 1'b0;
   logic [3:0] c_rx = 4'd15;
   logic [3:0] c_ry = 4'd0;

   logic        m_prev_org = 1'b0;
   logic        m_g = 1'b0;
   logic        m_hl = 1'b0;
   int          m_rx = 0;
   int          m_ry = 0;
   logic [14:0] m_rdx = '0;
   logic [14:0] m_rdy = '0;

   logic        nxt_hv = 1'b0;
   logic [7:0]  nxt_hc = 8'h00;
   logic        nxt_hren = 1'b0;
   logic [14:0] nxt_hrdx = '0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   // Checks outputs due now, then presents one pixel and advances the reference model
   task automatic step(input int x, input int y, input logic rst);
      logic        forced;
      int          lat;
      logic        in_a, org, fsx, outl, grd;
      logic [7:0]  col;
      @(negedge clk);
      chk("frame_start", int'(fs_w[0]), int'(hist[0].fs));
      chk("rd_en", int'(ren_w[0]), int'(hist[0].ren));
      chk("rd_x", int'(rdx_w[0]), int'(hist[0].rx));
      chk("rd_y", int'(rdy_w[0]), int'(hist[0].ry));
      if (hist[0].hv) begin
         chk("vec_rd_en", int'(ren_w[0]), int'(hist[0].hren));
         chk("vec_rd_x", int'(rdx_w[0]), int'(hist[0].hrdx));
      end
      if (hist[3].hv) chk("vec_colour", int'(col_w[0]), int'(hist[3].hcol));
      for (int g = 0; g < NI; g++) begin
         lat = lat_of(g);
         forced = 1'b0;
         for (int i = 0; i <= lat + 1; i++) if (hist[i].rst) forced = 1'b1;
         chk($sformatf("colour_lat%0d", lat), int'(col_w[g]),
             forced ? 0 : int'(hist[lat+1].col));
      end
      last_col = col_w[0];
      if (fs_w[0]) fs_seen++;

      reset   = rst;
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      grid_en = c_grid;
      robot_x = c_rx;
      robot_y = c_ry;

      org  = (x == 0) && (y == 0);
      in_a = (x < 330) && (y < 330);
      fsx  = !rst && org && !m_prev_org;
      if (fsx) begin
         m_g  = c_grid;
         m_hl = (c_rx <= 4'd10) && (c_ry <= 4'd10);
         m_rx = int'(c_rx);
         m_ry = int'(c_ry);
      end
      if (rst) begin
         m_g = 1'b0;
         m_hl = 1'b0;
         m_prev_org = 1'b0;
         m_rdx = '0;
         m_rdy = '0;
      end else begin
         m_prev_org = org;
         if (in_a) begin
            m_rdx = 15'(x);
            m_rdy = 15'(y);
         end
      end
      outl = m_hl && (x / 30 == m_rx) && (y / 30 == m_ry) &&
             ((x % 30) < 2 || (x % 30) > 27 || (y % 30) < 2 || (y % 30) > 27);
      grd  = m_g && ((x % 30) == 0 || (y % 30) == 0);
      if (!in_a)     col = 8'h00;
      else if (outl) col = 8'hFF;
      else if (grd)  col = 8'h92;
      else           col = cmap(memf(x, y));

      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{col, fsx, !rst && in_a, m_rdx, m_rdy, rst, nxt_hv, nxt_hc, nxt_hren, nxt_hrdx};
      nxt_hv = 1'b0;
   endtask

   task automatic scan_frame(input int fr);
      for (int y = 0; y < 332; y++) begin
         int xmax;
         xmax = (y < 32 || y >= 328) ? 334 : 3;
         for (int x = 0; x <= xmax; x++) begin
            if (fr == 1 && y == 10 && x == 0) c_rx = 4'd3;
            for (int i = 0; i < NSPOT; i++) begin
               if (spots[i].fr == fr && spots[i].x == x && spots[i].y == y) begin
                  nxt_hv   = 1'b1;
                  nxt_hc   = spots[i].col;
                  nxt_hren = 1'b1;
                  nxt_hrdx = 15'(x);
               end
            end
            step(x, y, 1'b0);
         end
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++)
         hist[i] = '{8'h00, 1'b0, 1'b0, 15'd0, 15'd0, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0};

      tbl[0]  = '{0,   0, 1'b1, 0,   8'h03};
      tbl[1]  = '{329, 0, 1'b1, 329, 8'hF0};
      tbl[2]  = '{330, 0, 1'b0, 329, 8'h00};
      tbl[3]  = '{700, 0, 1'b0, 329, 8'h00};
      tbl[4]  = '{0,   5, 1'b1, 0,   8'hF0};
      tbl[5]  = '{9,   5, 1'b1, 9,   8'hF0};
      tbl[6]  = '{10,  5, 1'b1, 10,  8'hF0};
      tbl[7]  = '{11,  5, 1'b1, 11,  8'h03};
      tbl[8]  = '{12,  5, 1'b1, 12,  8'hF0};
      tbl[9]  = '{4,   7, 1'b1, 4,   8'h00};
      tbl[10] = '{5,   7, 1'b1, 5,   8'h03};
      tbl[11] = '{6,   7, 1'b1, 6,   8'hE0};
      tbl[12] = '{7,   7, 1'b1, 7,   8'hF0};

      spots[0]  = '{0, 0,   0,   8'hFF};
      spots[1]  = '{0, 1,   15,  8'hFF};
      spots[2]  = '{0, 28,  15,  8'hFF};
      spots[3]  = '{0, 30,  15,  8'h92};
      spots[4]  = '{0, 300, 31,  8'h92};
      spots[5]  = '{0, 15,  30,  8'h92};
      spots[6]  = '{0, 15,  15,  8'h03};
      spots[7]  = '{0, 329, 329, 8'hE0};
      spots[8]  = '{1, 60,  15,  8'hFF};
      spots[9]  = '{1, 89,  15,  8'hFF};
      spots[10] = '{1, 90,  15,  8'h03};
      spots[11] = '{1, 60,  20,  8'hFF};
      spots[12] = '{1, 90,  20,  8'hF0};
      spots[13] = '{2, 60,  20,  8'hF0};
      spots[14] = '{2, 90,  20,  8'hFF};

      // Reset held at power-up
      for (int i = 0; i < 3; i++) step(700, 700, 1'b1);
      step(700, 700, 1'b0);

      // Hand-computed vectors: grid off, highlight disabled by robot_x = 15
      c_grid = 1'b0;
      c_rx   = 4'd15;
      c_ry   = 4'd0;
      for (int i = 0; i < NVEC; i++) begin
         nxt_hv   = 1'b1;
         nxt_hc   = tbl[i].col;
         nxt_hren = tbl[i].ren;
         nxt_hrdx = 15'(tbl[i].rdx);
         step(tbl[i].x, tbl[i].y, 1'b0);
      end
      for (int i = 0; i < 6; i++) step(700, 7, 1'b0);

      // Reset for three cycles mid-scan, then measure the refill
      for (int x = 90; x < 100; x++) step(x, 8, 1'b0);
      for (int x = 100; x < 103; x++) step(x, 8, 1'b1);
      n = 0;
      do begin
         step(103 + n, 8, 1'b0);
         n++;
      end while (last_col == 8'h00 && n < 20);
      chk("refill_cycles", n - 1, 4);
      for (int x = 103 + n; x < 140; x++) step(x, 8, 1'b0);

      // Frame start coincident with reset is suppressed
      fs_seen = 0;
      step(0, 0, 1'b1);
      step(0, 0, 1'b1);
      for (int i = 0; i < 6; i++) step(700, 700, 1'b0);
      chk("fs_with_reset", fs_seen, 0);

      // Frame 0: grid on, robot on tile (0,0)
      c_grid = 1'b1;
      c_rx = 4'd0;
      c_ry = 4'd0;
      fs_seen = 0;
      scan_frame(0);
      chk("fs_count_f0", fs_seen, 1);

      // Frame 1: grid off, robot_x moves 2 -> 3 mid-frame
      c_grid = 1'b0;
      c_rx = 4'd2;
      fs_seen = 0;
      scan_frame(1);
      chk("fs_count_f1", fs_seen, 1);

      // Frame 2: the move takes effect
      fs_seen = 0;
      scan_frame(2);
      chk("fs_count_f2", fs_seen, 1);

      for (int i = 0; i < 8; i++) step(700, 700, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
